adf4158_ramp_sched: RTL and testbench

Ramp scheduler for the ADF4158 FMCW synthesizer. After the configuration writer has loaded the PLL registers, this block waits for PLL lock and issues bursts of ramp triggers on the PLL TXDATA pin. For each ramp it opens an acquisition window for the ADC capture path after a settling interval. It enforces the dead time between ramps, counts ramps, and aborts on lock loss or lock timeout.

---
 rtl/adf4158_ramp_sched.sv | 175 +++++++++++++++++
 tb/tb_adf4158_ramp_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adf4158_ramp_sched.sv
// rtl/adf4158_ramp_sched.sv - ADF4158 ramp scheduler: lock wait, TXDATA trigger bursts, ADC acquisition windows.
module adf4158_ramp_sched #(
   parameter int TRIG_LEN     = 4,
   parameter int SETTLE_LEN   = 400,
   parameter int ACQ_LEN      = 20000,
   parameter int GAP_LEN      = 2000,
   parameter int LOCK_TIMEOUT = 40000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        cfg_done_i,
   input  logic        lock_i,
   input  logic        start_i,
   input  logic        stop_i,
   input  logic [15:0] num_ramps_i,
   output logic        txdata_o,
   output logic        acq_o,
   output logic [15:0] ramp_idx_o,
   output logic        busy_o,
   output logic        err_o
);

   localparam int MAX_A   = (TRIG_LEN > SETTLE_LEN) ? TRIG_LEN : SETTLE_LEN;
   localparam int MAX_B   = (ACQ_LEN > GAP_LEN) ? ACQ_LEN : GAP_LEN;
   localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_LEN = (MAX_C > LOCK_TIMEOUT) ? MAX_C : LOCK_TIMEOUT;
   localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [CW-1:0] TRIG_LOAD   = CW'(TRIG_LEN - 1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_LEN - 1);
   localparam logic [CW-1:0] ACQ_LOAD    = CW'(ACQ_LEN - 1);
   localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_LEN - 1);
   localparam logic [CW-1:0] LOCK_LOAD   = CW'(LOCK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_LOCK,
      S_TRIG,
      S_SETTLE,
      S_ACQ,
      S_GAP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   num_ramps_q, num_ramps_d;
   logic [15:0]   ramp_idx_d;
   logic [15:0]   ramp_idx_inc;
   logic          stop_pend_q, stop_pend_d;
   logic          err_d;
   logic          lock_q1, lock_s;
   logic          stop_req;
   logic          cnt_zero;

   // Losing cfg_done mid-burst ends the burst gracefully, exactly like stop_i.
   assign stop_req     = stop_i | ~cfg_done_i;
   assign cnt_zero     = (cnt_q == '0);
   assign ramp_idx_inc = ramp_idx_o + 16'd1;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lock_q1 <= 1'b0;
         lock_s  <= 1'b0;
      end else begin
         lock_q1 <= lock_i;
         lock_s  <= lock_q1;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      num_ramps_d = num_ramps_q;
      ramp_idx_d  = ramp_idx_o;
      stop_pend_d = stop_pend_q;
      err_d       = err_o;

      case (state_q)
         S_IDLE: begin
            if (start_i && cfg_done_i) begin
               state_d     = S_WAIT_LOCK;
               cnt_d       = LOCK_LOAD;
               num_ramps_d = num_ramps_i;
               ramp_idx_d  = 16'd0;
               stop_pend_d = 1'b0;
               err_d       = 1'b0;
            end
         end

         S_WAIT_LOCK: begin
            if (stop_req) begin
               state_d = S_IDLE;
            end else if (lock_s) begin
               state_d = S_TRIG;
               cnt_d   = TRIG_LOAD;
            end else if (cnt_zero) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_TRIG, S_SETTLE, S_ACQ, S_GAP: begin
            if (!lock_s) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               if (stop_req) begin
                  stop_pend_d = 1'b1;
               end
               if (!cnt_zero) begin
                  cnt_d = cnt_q - 1'b1;
               end else begin
                  case (state_q)
                     S_TRIG: begin
                        state_d = S_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                     end
                     S_SETTLE: begin
                        state_d = S_ACQ;
                        cnt_d   = ACQ_LOAD;
                     end
                     S_ACQ: begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                     end
                     default: begin
                        // End of GAP closes the ramp; a stop seen in this same cycle still counts.
                        ramp_idx_d = ramp_idx_inc;
                        if (stop_pend_q || stop_req ||
                            ((num_ramps_q != 16'd0) && (ramp_idx_inc == num_ramps_q))) begin
                           state_d = S_IDLE;
                        end else begin
                           state_d = S_TRIG;
                           cnt_d   = TRIG_LOAD;
                        end
                     end
                  endcase
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they change on the same edge as the state.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         num_ramps_q <= 16'd0;
         stop_pend_q <= 1'b0;
         ramp_idx_o  <= 16'd0;
         err_o       <= 1'b0;
         txdata_o    <= 1'b0;
         acq_o       <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         num_ramps_q <= num_ramps_d;
         stop_pend_q <= stop_pend_d;
         ramp_idx_o  <= ramp_idx_d;
         err_o       <= err_d;
         txdata_o    <= (state_d == S_TRIG);
         acq_o       <= (state_d == S_ACQ);
         busy_o      <= (state_d != S_IDLE);
      end
   end

endmodule

// File: tb/tb_adf4158_ramp_sched.sv
// tb/tb_adf4158_ramp_sched.sv - directed self-checking bench for adf4158_ramp_sched.
module tb_adf4158_ramp_sched;

   localparam int PERIOD = 17;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cfg_done = 1'b0;
   logic        lock = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] num_ramps = 16'd0;
   logic        txdata;
   logic        acq;
   logic [15:0] ramp_idx;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;

   adf4158_ramp_sched #(
      .TRIG_LEN(2),
      .SETTLE_LEN(3),
      .ACQ_LEN(8),
      .GAP_LEN(4),
      .LOCK_TIMEOUT(16)
   ) dut (
      .clk_i(clk),
      .rst_n_i(rst_n),
      .cfg_done_i(cfg_done),
      .lock_i(lock),
      .start_i(start),
      .stop_i(stop),
      .num_ramps_i(num_ramps),
      .txdata_o(txdata),
      .acq_o(acq),
      .ramp_idx_o(ramp_idx),
      .busy_o(busy),
      .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Called one cycle after the accepting edge (c=1). Checks {busy,txdata,acq,err,idx} every
   // cycle until a few cycles after the burst of r_tot ramps must have ended.
   task automatic run_expect(input int r_tot, input int stop_edge, input int start_edge,
                             input string tag);
      int last;
      logic [19:0] exp_v;
      logic [19:0] got_v;
      last = 2 + PERIOD * r_tot;
      for (int c = 1; c <= last + 3; c++) begin
         if (c >= last) begin
            exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 16'(r_tot)};
         end else if (c == 1) begin
            exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
         end else begin
            int p;
            int r;
            p = (c - 2) % PERIOD;
            r = (c - 2) / PERIOD;
            exp_v = {1'b1, (p < 2), (p >= 5 && p < 13), 1'b0, 16'(r)};
         end
         got_v = {busy, txdata, acq, err, ramp_idx};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d: {busy,tx,acq,err,idx} got %h expected %h",
                     tag, c, got_v, exp_v);
         end
         if (c + 1 == stop_edge) stop = 1'b1;
         if (c + 1 == start_edge) start = 1'b1;
         tick();
         stop = 1'b0;
         start = 1'b0;
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if ({busy, txdata, acq, err, ramp_idx} !== 20'h0) begin
         errors++;
         $display("FAIL reset_async: got %h expected 0", {busy, txdata, acq, err, ramp_idx});
      end
      cfg_done = 1'b1;
      lock = 1'b1;
      start = 1'b1;
      tick(2);
      start = 1'b0;
      checks++;
      if ({busy, txdata, acq, err, ramp_idx} !== 20'h0) begin
         errors++;
         $display("FAIL reset_held: got %h expected 0", {busy, txdata, acq, err, ramp_idx});
      end
      rst_n = 1'b1;
      tick(3);
   endtask

   task automatic test_normal_burst();
      num_ramps = 16'd3;
      pulse_start();
      run_expect(3, 0, 0, "normal_burst");
   endtask

   task automatic test_lock_timeout();
      lock = 1'b0;
      tick(3);
      num_ramps = 16'd1;
      pulse_start();
      for (int c = 1; c <= 16; c++) begin
         checks++;
         if ({busy, txdata} !== 2'b10) begin
            errors++;
            $display("FAIL lock_wait cycle %0d: {busy,tx} got %b expected 10", c, {busy, txdata});
         end
         tick();
      end
      checks++;
      if ({busy, err, txdata} !== 3'b010) begin
         errors++;
         $display("FAIL lock_timeout: {busy,err,tx} got %b expected 010", {busy, err, txdata});
      end
      // start without cfg_done is ignored and leaves the sticky error alone
      cfg_done = 1'b0;
      pulse_start();
      tick();
      checks++;
      if ({busy, err} !== 2'b01) begin
         errors++;
         $display("FAIL start_no_cfg: {busy,err} got %b expected 01", {busy, err});
      end
      cfg_done = 1'b1;
      lock = 1'b1;
      tick(3);
      pulse_start();
      run_expect(1, 0, 0, "err_clear_restart");
   endtask

   task automatic test_stop_mid_ramp();
      num_ramps = 16'd0;
      pulse_start();
      // edge 95 lies inside ACQ of ramp 5 (cycles 92..99)
      run_expect(6, 95, 0, "stop_mid_ramp");
      tick(10);
      checks++;
      if ({busy, txdata, ramp_idx} !== {2'b00, 16'd6}) begin
         errors++;
         $display("FAIL stop_stays_idle: {busy,tx,idx} got %h expected %h",
                  {busy, txdata, ramp_idx}, {2'b00, 16'd6});
      end
   endtask

   task automatic test_lock_loss();
      num_ramps = 16'd0;
      pulse_start();
      tick(25);
      lock = 1'b0;
      tick();
      checks++;
      if ({busy, acq} !== 2'b11) begin
         errors++;
         $display("FAIL lock_loss_c1: {busy,acq} got %b expected 11", {busy, acq});
      end
      tick();
      checks++;
      if ({busy, acq} !== 2'b11) begin
         errors++;
         $display("FAIL lock_loss_c2: {busy,acq} got %b expected 11", {busy, acq});
      end
      tick();
      checks++;
      if ({busy, acq, txdata, err, ramp_idx} !== {4'b0001, 16'd1}) begin
         errors++;
         $display("FAIL lock_loss_drop: {busy,acq,tx,err,idx} got %h expected %h",
                  {busy, acq, txdata, err, ramp_idx}, {4'b0001, 16'd1});
      end
      lock = 1'b1;
      tick(3);
   endtask

   task automatic test_gating();
      num_ramps = 16'd2;
      pulse_start();
      // a second start during the burst must not restart anything
      run_expect(2, 0, 10, "start_while_busy");
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      run_expect(2, 0, 0, "start_stop_idle");
   endtask

   task automatic test_reset_mid_trig();
      num_ramps = 16'd3;
      pulse_start();
      tick();
      checks++;
      if (txdata !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_trig: txdata got %b expected 1", txdata);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({txdata, busy, ramp_idx} !== 18'h0) begin
         errors++;
         $display("FAIL reset_mid_trig: {tx,busy,idx} got %h expected 0", {txdata, busy, ramp_idx});
      end
      #2 rst_n = 1'b1;
      tick(3);
      pulse_start();
      run_expect(3, 0, 0, "burst_after_reset");
   endtask

   initial begin
      test_reset();
      test_normal_burst();
      test_lock_timeout();
      test_stop_mid_ramp();
      test_lock_loss();
      test_gating();
      test_reset_mid_trig();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
